// File: rtl/c_tile_drain.sv
`default_nettype none
// ============================================================================
// Module   : c_tile_drain
// Purpose  : Reads a finished C tile from the output BRAM in row-major order,
//            requantizes each accumulator (rounding right-shift and signed
//            saturation) and streams it out on a valid/ready port. A 2-entry
//            skid buffer absorbs the 1-cycle BRAM read latency.
// Options  : `define C_TILE_DRAIN_PERF_EN adds the stall_cycles counter port.
// Revision : 1.0 - initial release
// ============================================================================
module c_tile_drain #(
  parameter int N      = 8,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 8,
  parameter int ADDR_W = $clog2(N*N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [15:0]             rows,
  input  logic [15:0]             cols,
  input  logic [4:0]              shift,
  output logic                    bram_re,
  output logic [ADDR_W-1:0]       bram_raddr,
  input  logic signed [ACC_W-1:0] bram_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
`ifdef C_TILE_DRAIN_PERF_EN
  ,
  output logic [31:0]             stall_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0]     C_N_ADDR  = ADDR_W'(N);
  localparam logic [15:0]           C_N_CNT   = 16'(N);
  localparam logic signed [ACC_W:0] C_SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] C_SAT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  state_t              state_q;
  logic [15:0]         rows_q, cols_q, row_q, col_q;
  logic [4:0]          shift_q;
  logic [ADDR_W-1:0]   addr_q, row_base_q;
  logic                busy_q, done_q;
  logic                inflight_q, inflight_last_q;

  // skid buffer storage
  logic [OUT_W-1:0]    buf_data_q [2];
  logic                buf_last_q [2];
  logic                rd_ptr_q, wr_ptr_q;
  logic [1:0]          cnt_q;

  logic                w_hs, w_start_ok, w_last_rc, w_credit, w_issue;
  logic [15:0]         w_rows_eff, w_cols_eff;
  logic [4:0]          w_shift_eff;
  logic signed [ACC_W:0] w_ext, w_rnd, w_sum, w_y;
  logic [OUT_W-1:0]    w_q;

  assign w_hs       = out_valid && out_ready;
  assign w_start_ok = start && (state_q == S_IDLE) && !done_q;
  assign w_last_rc  = (row_q == rows_q - 16'd1) && (col_q == cols_q - 16'd1);
  // A pop this cycle frees a slot for this cycle's issue decision.
  assign w_credit   = ({1'b0, cnt_q} + {2'b00, inflight_q}) <= (3'd1 + {2'b00, w_hs});
  assign w_issue    = (state_q == S_RUN) && w_credit;

  assign w_rows_eff  = ((rows == 16'd0) || (rows > C_N_CNT)) ? C_N_CNT : rows;
  assign w_cols_eff  = ((cols == 16'd0) || (cols > C_N_CNT)) ? C_N_CNT : cols;
  assign w_shift_eff = ({27'd0, shift} >= 32'(ACC_W)) ? 5'(ACC_W - 1) : shift;

  assign bram_re    = w_issue;
  assign bram_raddr = addr_q;
  assign out_valid  = (cnt_q != 2'd0);
  assign out_data   = buf_data_q[rd_ptr_q];
  assign out_last   = buf_last_q[rd_ptr_q];
  assign busy       = busy_q;
  assign done       = done_q;

  // Requantize the read word: widen by one bit so the rounding add cannot overflow.
  always_comb begin
    w_ext = $signed({bram_rdata[ACC_W-1], bram_rdata});
    w_rnd = '0;
    if (shift_q != 5'd0) begin
      w_rnd = $signed({{ACC_W{1'b0}}, 1'b1} << (shift_q - 5'd1));
    end
    w_sum = w_ext + w_rnd;
    w_y   = w_sum >>> shift_q;
    if (w_y > C_SAT_MAX) begin
      w_q = C_SAT_MAX[OUT_W-1:0];
    end else if (w_y < C_SAT_MIN) begin
      w_q = C_SAT_MIN[OUT_W-1:0];
    end else begin
      w_q = w_y[OUT_W-1:0];
    end
  end

  // Drain FSM: sequences read addresses and generates busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      rows_q          <= 16'd0;
      cols_q          <= 16'd0;
      row_q           <= 16'd0;
      col_q           <= 16'd0;
      shift_q         <= 5'd0;
      addr_q          <= '0;
      row_base_q      <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      done_q          <= 1'b0;
      inflight_q      <= w_issue;
      inflight_last_q <= w_issue && w_last_rc;
      case (state_q)
        S_IDLE: begin
          if (w_start_ok) begin
            rows_q     <= w_rows_eff;
            cols_q     <= w_cols_eff;
            shift_q    <= w_shift_eff;
            row_q      <= 16'd0;
            col_q      <= 16'd0;
            addr_q     <= '0;
            row_base_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_issue) begin
            if (w_last_rc) begin
              state_q <= S_DRAIN;
            end else if (col_q == cols_q - 16'd1) begin
              col_q      <= 16'd0;
              row_q      <= row_q + 16'd1;
              row_base_q <= row_base_q + C_N_ADDR;
              addr_q     <= row_base_q + C_N_ADDR;
            end else begin
              col_q  <= col_q + 16'd1;
              addr_q <= addr_q + ADDR_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (w_hs && out_last) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Skid buffer: write when read data returns, pop on handshake, FIFO order.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_last_q[0] <= 1'b0;
      buf_last_q[1] <= 1'b0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      cnt_q         <= 2'd0;
    end else begin
      if (inflight_q) begin
        buf_data_q[wr_ptr_q] <= w_q;
        buf_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (w_hs) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({inflight_q, w_hs})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef C_TILE_DRAIN_PERF_EN
  logic [31:0] stall_q;
  assign stall_cycles = stall_q;

  // Count backpressure cycles, saturating; cleared by an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 32'd0;
    end else if (w_start_ok) begin
      stall_q <= 32'd0;
    end else if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire
